ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter. It is the opposite direction of the existing PS/2 keyboard receiver.
- It sends command bytes to the keyboard, for example 0xED to set the LEDs for CAPS/KANA, and 0xFF for a reset.
- It sits beside the receiver on the same ps2Clk/ps2Data open-collector pins and runs on cpuClock.
- The top-level drives each pin low when the matching *_oe output is 1, and tri-states it otherwise.

---
 rtl/ps2_host_tx_if.sv | 20 ++
 rtl/ps2_host_tx.sv | 174 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a host controller and the PS/2 host transmitter.
// The master offers a byte; the slave accepts it and reports completion and error.
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, busy, tx_done, tx_error
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, busy, tx_done, tx_error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter sharing the open-collector clock/data pins with the receiver.
// Define PS2_TX_RETRY_EN to retry a NAKed or timed-out command once before reporting.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2800,
  parameter int TIMEOUT_CYCLES = 420000,
  parameter int TO_W           = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  ps2_host_tx_if.slave      tx,
  input  logic              ps2_clk_in,
  input  logic              ps2_data_in,
  output logic              ps2_clk_oe,
  output logic              ps2_data_oe
);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE} state_t;

  localparam logic [TO_W-1:0] INH_LAST = TO_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [3:0]      idx_q, idx_d;
  logic [9:0]      frame_q, frame_d;
  logic            nak_q, nak_d;
  logic            clk_s1, clk_s2, clk_s3, fall_q;
  logic            data_s1, data_s2;
  logic            clk_oe_q, data_oe_q, ready_q, busy_q, done_q, err_q;
  logic            clk_oe_d, data_oe_d, ready_d, busy_d, done_d, err_d;
  logic            accept, restart, can_retry, timeout, line_idle, bad;

  // Sync flops idle high so reset never fabricates a falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      clk_s3  <= 1'b1;
      fall_q  <= 1'b0;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk_in;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      fall_q  <= clk_s3 & ~clk_s2;
      data_s1 <= ps2_data_in;
      data_s2 <= data_s1;
    end
  end

`ifdef PS2_TX_RETRY_EN
  logic retry_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     retry_q <= 1'b0;
    else if (accept)  retry_q <= 1'b0;
    else if (restart) retry_q <= 1'b1;
  end

  assign can_retry = ~retry_q;
`else
  assign can_retry = 1'b0;
`endif

  assign accept    = (state_q == IDLE) && tx.tx_valid && ready_q;
  assign timeout   = (state_q == SHIFT || state_q == ACK || state_q == WAIT_IDLE) && (cnt_q == TO_LAST);
  assign line_idle = (state_q == WAIT_IDLE) && clk_s2 && data_s2;
  assign bad       = timeout || nak_q;
  assign restart   = (timeout || line_idle) && bad && can_retry;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    nak_d   = nak_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          frame_d = {~^tx.tx_data, tx.tx_data, 1'b0};
          nak_d   = 1'b0;
          cnt_d   = '0;
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d   = '0;
          state_d = REQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REQ: begin
        idx_d   = 4'd0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (fall_q) begin
          if (idx_q == 4'd9) state_d = ACK;
          else               idx_d   = idx_q + 4'd1;
        end
      end
      ACK: begin
        cnt_d = cnt_q + 1'b1;
        if (fall_q) begin
          nak_d   = data_s2;
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: cnt_d = cnt_q + 1'b1;
      default:   state_d = IDLE;
    endcase

    // Timeout and end-of-frame share one exit: retry once if allowed, otherwise report.
    if (timeout || line_idle) begin
      if (restart) begin
        nak_d   = 1'b0;
        cnt_d   = '0;
        state_d = INHIBIT;
      end else begin
        done_d  = 1'b1;
        err_d   = bad;
        state_d = IDLE;
      end
    end

    clk_oe_d  = (state_d == INHIBIT) || (state_d == REQ);
    data_oe_d = (state_d == REQ) || ((state_d == SHIFT) && !frame_d[idx_d]);
    ready_d   = (state_d == IDLE) && !done_d;
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= 4'd0;
      frame_q   <= '0;
      nak_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      nak_q     <= nak_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx.tx_ready = ready_q;
  assign tx.busy     = busy_q;
  assign tx.tx_done  = done_q;
  assign tx.tx_error = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-collector PS/2 device model.
// Short inhibit/timeout parameters keep the run small.
module tb_ps2_host_tx;
  localparam int INH  = 20;
  localparam int TO   = 3000;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic ps2_clk_oe, ps2_data_oe;
  logic ps2_clk_in, ps2_data_in;
  logic [10:0] seen;
  int checks = 0;
  int errors = 0;
  int n;

  ps2_host_tx_if txi();

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .TO_W(20)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .tx(txi.slave),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_tx(input logic [7:0] b, input logic hold);
    @(negedge clk);
    check("ready_before_accept", {31'd0, txi.tx_ready}, 1);
    txi.tx_valid = 1'b1;
    txi.tx_data  = b;
    @(negedge clk);
    if (!hold) begin
      txi.tx_valid = 1'b0;
      txi.tx_data  = 8'h55;
    end
    check("busy_after_accept", {31'd0, txi.busy}, 1);
  endtask

  // Called on the first INHIBIT cycle; returns on the first SHIFT cycle.
  task automatic measure_inhibit(input string tag);
    int k = 0;
    while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && k < INH + 100) begin
      k++;
      @(negedge clk);
    end
    check({tag, "_inhibit_len"}, k, INH);
    check({tag, "_req"}, {30'd0, ps2_clk_oe, ps2_data_oe}, 2'b11);
    @(negedge clk);
    check({tag, "_start_bit"}, {30'd0, ps2_clk_oe, ps2_data_oe}, 2'b01);
  endtask

  // Device clocks the frame, sampling data while its clock is high.
  task automatic device_run(input logic ack_bit, input int edges, output logic [10:0] bits);
    bits = '0;
    for (int i = 0; i < edges; i++) begin
      repeat (HALF) @(negedge clk);
      bits[i] = ~ps2_data_oe;
      if (i == 10) dev_data = ack_bit;
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
    end
    dev_data = 1'b1;
  endtask

  task automatic wait_done(input string tag, input logic exp_err);
    int k = 0;
    while (txi.tx_done !== 1'b1 && k < TO + 200) begin
      k++;
      @(negedge clk);
    end
    check({tag, "_done"}, {31'd0, txi.tx_done}, 1);
    check({tag, "_error"}, {31'd0, txi.tx_error}, {31'd0, exp_err});
    check({tag, "_lines_released"}, {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
    check({tag, "_ready_in_done"}, {31'd0, txi.tx_ready}, 0);
    @(negedge clk);
    check({tag, "_done_single"}, {31'd0, txi.tx_done}, 0);
    check({tag, "_ready_after"}, {31'd0, txi.tx_ready}, 1);
    check({tag, "_busy_after"}, {31'd0, txi.busy}, 0);
  endtask

  task automatic wait_clk_oe();
    int k = 0;
    while (ps2_clk_oe !== 1'b1 && k < TO + 200) begin
      k++;
      @(negedge clk);
    end
  endtask

  initial begin
    txi.tx_valid = 1'b0;
    txi.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, txi.tx_ready}, 1);
    check("rst_busy", {31'd0, txi.busy}, 0);
    check("rst_done", {31'd0, txi.tx_done}, 0);
    check("rst_error", {31'd0, txi.tx_error}, 0);
    check("rst_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
    reset_n = 1'b1;

    start_tx(8'hED, 1'b0);
    measure_inhibit("ed");
    device_run(1'b0, 11, seen);
    check("ed_frame", {21'd0, seen}, {21'd0, 1'b1, 1'b1, 8'hED, 1'b0});
    wait_done("ed", 1'b0);

    start_tx(8'h07, 1'b0);
    measure_inhibit("x07");
    device_run(1'b0, 11, seen);
    check("x07_frame", {21'd0, seen}, {21'd0, 1'b1, 1'b0, 8'h07, 1'b0});
    check("x07_parity", {31'd0, seen[9]}, 0);
    wait_done("x07", 1'b0);

    start_tx(8'h00, 1'b0);
    measure_inhibit("x00");
    device_run(1'b0, 11, seen);
    check("x00_frame", {21'd0, seen}, {21'd0, 1'b1, 1'b1, 8'h00, 1'b0});
    check("x00_parity", {31'd0, seen[9]}, 1);
    wait_done("x00", 1'b0);

    start_tx(8'hFF, 1'b0);
    measure_inhibit("nak");
    device_run(1'b1, 11, seen);
    check("nak_frame", {21'd0, seen}, {21'd0, 1'b1, 1'b1, 8'hFF, 1'b0});
`ifdef PS2_TX_RETRY_EN
    wait_clk_oe();
    measure_inhibit("nak_retry");
    device_run(1'b1, 11, seen);
    check("nak_retry_frame", {21'd0, seen}, {21'd0, 1'b1, 1'b1, 8'hFF, 1'b0});
`endif
    wait_done("nak", 1'b1);

    start_tx(8'hFF, 1'b0);
    measure_inhibit("tmo");
    n = 0;
    while (txi.tx_done !== 1'b1 && ps2_clk_oe !== 1'b1 && n < TO + 100) begin
      n++;
      @(negedge clk);
    end
    check("tmo_len", n, TO);
`ifdef PS2_TX_RETRY_EN
    measure_inhibit("tmo_retry");
    n = 0;
    while (txi.tx_done !== 1'b1 && n < TO + 100) begin
      n++;
      @(negedge clk);
    end
    check("tmo_retry_len", n, TO);
`endif
    wait_done("tmo", 1'b1);

    // Reset mid-frame, between clock edges.
    start_tx(8'hF4, 1'b0);
    measure_inhibit("rstmid");
    device_run(1'b0, 5, seen);
    check("rstmid_partial", {27'd0, seen[4:0]}, {27'd0, 5'b01000});
    #2 reset_n = 1'b0;
    #1;
    check("rstmid_lines_async", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (txi.tx_done === 1'b1) n++;
    end
    check("rstmid_no_done", n, 0);
    reset_n = 1'b1;
    start_tx(8'hF4, 1'b0);
    measure_inhibit("f4");
    device_run(1'b0, 11, seen);
    check("f4_frame", {21'd0, seen}, {21'd0, 1'b1, 1'b0, 8'hF4, 1'b0});
    wait_done("f4", 1'b0);

    // tx_valid held through a transaction: one frame, then a new one right after IDLE.
    start_tx(8'hAA, 1'b1);
    measure_inhibit("aa1");
    device_run(1'b0, 11, seen);
    check("aa1_frame", {21'd0, seen}, {21'd0, 1'b1, 1'b1, 8'hAA, 1'b0});
    wait_done("aa1", 1'b0);
    @(negedge clk);
    txi.tx_valid = 1'b0;
    check("aa2_busy", {31'd0, txi.busy}, 1);
    measure_inhibit("aa2");
    device_run(1'b0, 11, seen);
    check("aa2_frame", {21'd0, seen}, {21'd0, 1'b1, 1'b1, 8'hAA, 1'b0});
    wait_done("aa2", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
